// File: rtl/fir_par3_ser_out_if.sv
// Stream interface for fir_par3_ser_out: a 3-lane parallel frame input side and
// a serial rounded/saturated sample output side, both valid/ready.
// Handshake rule for both sides: a beat transfers on a rising clk edge
// where valid && ready. The sender must hold its payload stable while
// valid is high and ready is low. ready never depends on valid.
interface fir_par3_ser_out_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  y_in0;
  logic signed [IN_W-1:0]  y_in1;
  logic signed [IN_W-1:0]  y_in2;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic [1:0]              out_lane;
  logic                    sat_flag;

  // Filter-core / bench side: produces frames, consumes samples
  modport master (
    output in_valid, y_in0, y_in1, y_in2, out_ready,
    input  in_ready, out_valid, out_data, out_lane, sat_flag
  );

  // Serializer side
  modport slave (
    input  in_valid, y_in0, y_in1, y_in2, out_ready,
    output in_ready, out_valid, out_data, out_lane, sat_flag
  );
endinterface

// File: rtl/fir_par3_ser_out.sv
// fir_par3_ser_out: buffers 3-lane parallel FIR results in a frame FIFO and
// emits them as one serial stream (lane 0, 1, 2), each sample rounded
// (half up), arithmetically shifted by SHIFT and saturated to OUT_W bits.
// Optional feature macro: FIR_P3S_SATCNT_EN adds a saturating 16-bit count
// of clipped output transfers (sat_count) with a synchronous clear (sat_clr).
module fir_par3_ser_out #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
`ifdef FIR_P3S_SATCNT_EN
  input  logic                      sat_clr,
  output logic [15:0]               sat_count,
`endif
  fir_par3_ser_out_if.slave         bus
);

  localparam int AW = $clog2(DEPTH);

  // Rounding constant 2^(SHIFT-1) at IN_W+1 bits so the add cannot overflow
  localparam logic signed [IN_W:0]  RND_C  = (IN_W+1)'(1) <<< (SHIFT-1);
  localparam logic signed [IN_W:0]  MAX_C  = (IN_W+1)'((2**(OUT_W-1)) - 1);
  localparam logic signed [IN_W:0]  MIN_C  = ~MAX_C;
  localparam logic [OUT_W-1:0]      OMAX_C = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]      OMIN_C = {1'b1, {(OUT_W-1){1'b0}}};

  // Frame storage, lane 0 in the top slice
  logic [3*IN_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q,  count_d;
  logic [1:0]        lane_q,   lane_d;

  logic              push;
  logic              pop;
  logic              xfer;
  logic              out_valid_w;

  logic [3*IN_W-1:0]     head;
  logic signed [IN_W-1:0] sel;
  logic signed [IN_W:0]   sum;
  logic signed [IN_W:0]   r;
  logic [OUT_W-1:0]       data_w;
  logic                   sat_w;

  // Handshake qualifiers; ready comes from the registered count only
  always_comb begin
    out_valid_w = (count_q != '0);
    push        = bus.in_valid && (count_q < (AW+1)'(DEPTH));
    xfer        = out_valid_w && bus.out_ready;
    pop         = xfer && (lane_q == 2'd2);
  end

  assign bus.in_ready  = (count_q < (AW+1)'(DEPTH));
  assign bus.out_valid = out_valid_w;

  // Next-state for pointers, occupancy and lane counter; flush has priority
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    lane_d   = lane_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      lane_d   = 2'd0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + (AW+1)'(1);
      else if (pop && !push) count_d = count_q - (AW+1)'(1);
      if (xfer) lane_d = (lane_q == 2'd2) ? 2'd0 : lane_q + 2'd1;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      lane_q   <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lane_q   <= lane_d;
    end
  end

  // Frame storage write; contents need no reset since out_valid gates them
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= {bus.y_in0, bus.y_in1, bus.y_in2};
  end

  // Lane select, round, shift and saturate of the head sample
  always_comb begin
    head   = mem_q[rd_ptr_q];
    case (lane_q)
      2'd0:    sel = head[3*IN_W-1 -: IN_W];
      2'd1:    sel = head[2*IN_W-1 -: IN_W];
      default: sel = head[IN_W-1   -: IN_W];
    endcase
    sum    = $signed({sel[IN_W-1], sel}) + RND_C;
    r      = sum >>> SHIFT;
    data_w = '0;
    sat_w  = 1'b0;
    if (out_valid_w) begin
      if (r > MAX_C) begin
        data_w = OMAX_C;
        sat_w  = 1'b1;
      end else if (r < MIN_C) begin
        data_w = OMIN_C;
        sat_w  = 1'b1;
      end else begin
        data_w = r[OUT_W-1:0];
      end
    end
  end

  assign bus.out_data = data_w;
  assign bus.sat_flag = sat_w;
  assign bus.out_lane = out_valid_w ? lane_q : 2'd0;

`ifdef FIR_P3S_SATCNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  // Clipped-transfer count: clears win, saturates at all-ones
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (flush || sat_clr)
      sat_cnt_d = '0;
    else if (xfer && sat_w && (sat_cnt_q != 16'hFFFF))
      sat_cnt_d = sat_cnt_q + 16'd1;
  end

  // Clipped-transfer count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_fir_par3_ser_out.sv
// Bench for fir_par3_ser_out: directed scenarios plus randomized traffic,
// scored against a queue of expected serial samples built from plain
// integer arithmetic on each accepted frame.
module tb_fir_par3_ser_out;
  localparam int IN_W  = 32;
  localparam int OUT_W = 16;
  localparam int SHIFT = 15;
  localparam int DEPTH = 4;
  localparam int EW    = 2 + 1 + OUT_W;

  logic clk;
  logic rst_n;
  logic flush;
`ifdef FIR_P3S_SATCNT_EN
  logic        sat_clr;
  logic [15:0] sat_count;
  int          sc_model;
`endif

  int tests_run;
  int tests_failed;

  // expected entry: {lane, sat, data}
  logic [EW-1:0] exp_q[$];

  fir_par3_ser_out_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus();

  fir_par3_ser_out #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
`ifdef FIR_P3S_SATCNT_EN
    .sat_clr   (sat_clr),
    .sat_count (sat_count),
`endif
    .bus       (bus)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: round half up, floor shift, clamp, using 64-bit integers
  function automatic logic [EW-1:0] ref_sample(input int lane, input logic [IN_W-1:0] v);
    longint x;
    longint r;
    logic [OUT_W-1:0] d;
    logic s;
    x = longint'($signed(v));
    r = (x + (longint'(1) <<< (SHIFT-1))) >>> SHIFT;
    if (r > 32767)       begin d = 16'h7FFF; s = 1'b1; end
    else if (r < -32768) begin d = 16'h8000; s = 1'b1; end
    else                 begin d = 16'(r);   s = 1'b0; end
    return {2'(lane), s, d};
  endfunction

  // scoreboard: sampled mid-cycle, so it sees what the next edge will do
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int frames;
    if (!rst_n) begin
      exp_q.delete();
`ifdef FIR_P3S_SATCNT_EN
      sc_model = 0;
`endif
    end else begin
      frames = (exp_q.size() + 2) / 3;
      tests_run++;
      if (bus.out_valid !== (exp_q.size() != 0) || bus.in_ready !== (frames < DEPTH)) begin
        tests_failed++;
        $display("FAIL sb_flags: out_valid=%0b in_ready=%0b expected %0b %0b", bus.out_valid,
                 bus.in_ready, (exp_q.size() != 0), (frames < DEPTH));
      end
`ifdef FIR_P3S_SATCNT_EN
      tests_run++;
      if (sat_count !== 16'(sc_model)) begin
        tests_failed++;
        $display("FAIL sb_sat_count: got %0d expected %0d", sat_count, sc_model);
      end
`endif
      if (flush) begin
        exp_q.delete();
`ifdef FIR_P3S_SATCNT_EN
        sc_model = 0;
`endif
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_extra: unexpected sample %h lane %0d", bus.out_data, bus.out_lane);
          end else begin
            e = exp_q.pop_front();
            if ({bus.out_lane, bus.sat_flag, bus.out_data} !== e) begin
              tests_failed++;
              $display("FAIL sb_sample: got lane=%0d sat=%0b data=%h expected lane=%0d sat=%0b data=%h",
                       bus.out_lane, bus.sat_flag, bus.out_data, e[EW-1 -: 2], e[OUT_W], e[OUT_W-1:0]);
            end
`ifdef FIR_P3S_SATCNT_EN
            if (!sat_clr && e[OUT_W] && sc_model != 65535) sc_model++;
`endif
          end
        end
`ifdef FIR_P3S_SATCNT_EN
        if (sat_clr) sc_model = 0;
`endif
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back(ref_sample(0, bus.y_in0));
          exp_q.push_back(ref_sample(1, bus.y_in1));
          exp_q.push_back(ref_sample(2, bus.y_in2));
        end
      end
    end
  end

  // drivers
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                            input logic [IN_W-1:0] c);
    bus.in_valid = 1'b1;
    bus.y_in0 = a;
    bus.y_in1 = b;
    bus.y_in2 = c;
    next_cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
      next_cycle();
      n++;
    end
    tests_run++;
    if (n >= 200) begin
      tests_failed++;
      $display("FAIL drain_timeout: %0d samples left, out_valid=%0b", exp_q.size(), bus.out_valid);
    end
  endtask

  function automatic logic [IN_W-1:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 32'h7FFFFFFF - 32'($urandom_range(0, 3000000));
      1:       return 32'h80000000 + 32'($urandom_range(0, 3000000));
      2:       return 32'($signed($urandom_range(0, 2000000)) - 1000000);
      default: return $urandom();
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
          bus.out_lane !== 2'd0 || bus.sat_flag !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_idle: in_ready=%0b out_valid=%0b data=%h lane=%0d sat=%0b expected 1 0 0000 0 0",
                 bus.in_ready, bus.out_valid, bus.out_data, bus.out_lane, bus.sat_flag);
      end
      next_cycle();
    end
  endtask

  task automatic check_frame(input string name, input logic [OUT_W-1:0] d0, input logic [OUT_W-1:0] d1,
                             input logic [OUT_W-1:0] d2, input logic [2:0] s);
    logic [OUT_W-1:0] d[3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== d[i] || bus.out_lane !== 2'(i) ||
          bus.sat_flag !== s[2-i]) begin
        tests_failed++;
        $display("FAIL %s lane%0d: valid=%0b data=%h lane=%0d sat=%0b expected 1 %h %0d %0b",
                 name, i, bus.out_valid, bus.out_data, bus.out_lane, bus.sat_flag, d[i], i, s[2-i]);
      end
      next_cycle();
    end
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s end: out_valid=%0b expected 0", name, bus.out_valid);
    end
  endtask

  task automatic test_ordering();
    bus.out_ready = 1'b1;
    push_frame(32'h00004000, 32'h00008000, 32'hFFFFC000);
    check_frame("ordering", 16'd1, 16'd1, 16'd0, 3'b000);
  endtask

  task automatic test_saturation();
    bus.out_ready = 1'b1;
    push_frame(32'h7FFFFFFF, 32'h80000000, 32'h3FFF8000);
    check_frame("saturation", 16'h7FFF, 16'h8000, 16'h7FFF, 3'b110);
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.y_in0 = rand_val(); bus.y_in1 = rand_val(); bus.y_in2 = rand_val();
      next_cycle();
      tests_run++;
      if (bus.in_ready !== (i < 3)) begin
        tests_failed++;
        $display("FAIL full_ready push%0d: in_ready=%0b expected %0b", i, bus.in_ready, (i < 3));
      end
    end
    bus.in_valid = 1'b0;
    tests_run++;
    if (exp_q.size() != 12) begin
      tests_failed++;
      $display("FAIL full_accepted: %0d samples queued expected 12", exp_q.size());
    end
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      tests_run++;
      if (bus.in_ready !== (k == 3)) begin
        tests_failed++;
        $display("FAIL full_reassert xfer%0d: in_ready=%0b expected %0b", k, bus.in_ready, (k == 3));
      end
    end
    drain();
  endtask

  task automatic test_stall();
    logic [OUT_W-1:0] held;
    bus.out_ready = 1'b0;
    push_frame(rand_val(), rand_val(), rand_val());
    bus.out_ready = 1'b1;
    next_cycle();
    bus.out_ready = 1'b0;
    held = bus.out_data;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_lane !== 2'd1 || bus.out_data !== held) begin
        tests_failed++;
        $display("FAIL stall_hold cyc%0d: valid=%0b lane=%0d data=%h expected 1 1 %h",
                 i, bus.out_valid, bus.out_lane, bus.out_data, held);
      end
    end
    drain();
  endtask

  task automatic test_flush();
    // synchronous flush after lane 0 of the head frame with two frames queued
    bus.out_ready = 1'b0;
    push_frame(32'h7FFFFFFF, rand_val(), rand_val());
    push_frame(rand_val(), rand_val(), rand_val());
    bus.out_ready = 1'b1;
    next_cycle();
    bus.out_ready = 1'b0;
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== '0) begin
      tests_failed++;
      $display("FAIL flush_state: out_valid=%0b in_ready=%0b data=%h expected 0 1 0000",
               bus.out_valid, bus.in_ready, bus.out_data);
    end
`ifdef FIR_P3S_SATCNT_EN
    tests_run++;
    if (sat_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL flush_sat_count: got %0d expected 0", sat_count);
    end
`endif
    // asynchronous reset pulse in the middle of a cycle
    push_frame(32'h80000000, rand_val(), rand_val());
    push_frame(rand_val(), rand_val(), rand_val());
    bus.out_ready = 1'b1;
    next_cycle();
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_lane !== 2'd0 || bus.out_data !== '0) begin
      tests_failed++;
      $display("FAIL async_reset_state: out_valid=%0b in_ready=%0b lane=%0d data=%h expected 0 1 0 0000",
               bus.out_valid, bus.in_ready, bus.out_lane, bus.out_data);
    end
`ifdef FIR_P3S_SATCNT_EN
    tests_run++;
    if (sat_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_sat_count: got %0d expected 0", sat_count);
    end
`endif
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    next_cycle();
    // frames after recovery behave normally
    bus.out_ready = 1'b1;
    push_frame(32'h00004000, 32'h00008000, 32'hFFFFC000);
    check_frame("post_reset", 16'd1, 16'd1, 16'd0, 3'b000);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom_range(0, 99) < 45);
      bus.y_in0 = rand_val(); bus.y_in1 = rand_val(); bus.y_in2 = rand_val();
      bus.out_ready = ($urandom_range(0, 99) < 70);
      flush = ($urandom_range(0, 99) < 2);
`ifdef FIR_P3S_SATCNT_EN
      sat_clr = ($urandom_range(0, 99) < 3);
`endif
      next_cycle();
    end
    bus.in_valid = 1'b0;
    flush = 1'b0;
`ifdef FIR_P3S_SATCNT_EN
    sat_clr = 1'b0;
`endif
    drain();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.in_valid = 1'b1;
      bus.y_in0 = rand_val(); bus.y_in1 = rand_val(); bus.y_in2 = rand_val();
      next_cycle();
    end
    bus.in_valid = 1'b0;
    drain();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.y_in0 = '0;
    bus.y_in1 = '0;
    bus.y_in2 = '0;
    bus.out_ready = 1'b0;
`ifdef FIR_P3S_SATCNT_EN
    sat_clr = 1'b0;
`endif
    test_reset();
    test_ordering();
    test_saturation();
    test_backpressure();
    test_stall();
    test_flush();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
